// File: rtl/xbar_sw_alloc.sv
// Switch allocator for the 5-port router crossbar (N/S/E/W/L).
// Each output runs its own round-robin arbiter with wormhole locking: once an
// input wins an output, it keeps that output until its tail flit transfers.
module xbar_sw_alloc #(
  parameter int                 ROUTE_W   = 3,
  parameter logic [ROUTE_W-1:0] IDLE_CODE = 3'b111,
  parameter int                 NPORT     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORT-1:0]         req_valid_i,
  input  logic [NPORT*ROUTE_W-1:0] req_dest_i,
  input  logic [NPORT-1:0]         req_tail_i,
  input  logic [NPORT-1:0]         out_ready_i,
  output logic [ROUTE_W-1:0]       address_route_n_o,
  output logic [ROUTE_W-1:0]       address_route_s_o,
  output logic [ROUTE_W-1:0]       address_route_e_o,
  output logic [ROUTE_W-1:0]       address_route_w_o,
  output logic [ROUTE_W-1:0]       address_route_l_o,
  output logic [NPORT-1:0]         out_valid_o,
  output logic [NPORT-1:0]         grant_o,
  output logic                     dest_err_o
);

  typedef enum logic {IDLE, LOCKED} lock_e;

  lock_e              lock_q   [NPORT];
  lock_e              lock_d   [NPORT];
  logic [ROUTE_W-1:0] owner_q  [NPORT];
  logic [ROUTE_W-1:0] owner_d  [NPORT];
  logic [ROUTE_W-1:0] rr_ptr_q [NPORT];
  logic [ROUTE_W-1:0] rr_ptr_d [NPORT];
  logic               dest_err_q;
  logic               dest_err_d;

  // req[o][k]: input k has a valid flit headed for output o
  logic [NPORT-1:0]   req       [NPORT];
  logic [ROUTE_W-1:0] route_sel [NPORT];

  // Request matrix and the sticky bad-destination detector
  always_comb begin
    dest_err_d = dest_err_q;
    for (int o = 0; o < NPORT; o++) begin
      for (int k = 0; k < NPORT; k++) begin
        req[o][k] = req_valid_i[k] &&
                    (req_dest_i[k*ROUTE_W +: ROUTE_W] == ROUTE_W'(o));
      end
    end
    for (int k = 0; k < NPORT; k++) begin
      if (req_valid_i[k] &&
          (req_dest_i[k*ROUTE_W +: ROUTE_W] > ROUTE_W'(NPORT - 1))) begin
        dest_err_d = 1'b1;
      end
    end
  end

  // Per-output arbitration, lock tracking, route selects and strobes
  always_comb begin
    logic owner_req;
    logic owner_tail;
    logic found;
    // NOTE: every output of this block gets a default first so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    out_valid_o = '0;
    grant_o     = '0;
    for (int o = 0; o < NPORT; o++) begin
      lock_d[o]    = lock_q[o];
      owner_d[o]   = owner_q[o];
      rr_ptr_d[o]  = rr_ptr_q[o];
      route_sel[o] = IDLE_CODE;
      owner_req    = 1'b0;
      owner_tail   = 1'b0;
      found        = 1'b0;

      if (lock_q[o] == LOCKED) begin
        route_sel[o] = owner_q[o];
        for (int k = 0; k < NPORT; k++) begin
          if (owner_q[o] == ROUTE_W'(k)) begin
            owner_req  = req[o][k];
            owner_tail = req_tail_i[k];
          end
        end
        if (owner_req && out_ready_i[o]) begin
          out_valid_o[o] = 1'b1;
          for (int k = 0; k < NPORT; k++) begin
            if (owner_q[o] == ROUTE_W'(k)) grant_o[k] = 1'b1;
          end
          if (owner_tail) lock_d[o] = IDLE;
        end
      end else begin
        // Scan from the input after the last winner, wrapping modulo NPORT
        for (int i = 1; i <= NPORT; i++) begin
          for (int k = 0; k < NPORT; k++) begin
            if (!found && req[o][k] &&
                (k == (int'(rr_ptr_q[o]) + i) % NPORT)) begin
              found       = 1'b1;
              lock_d[o]   = LOCKED;
              owner_d[o]  = ROUTE_W'(k);
              rr_ptr_d[o] = ROUTE_W'(k);
            end
          end
        end
      end
    end
  end

  // State registers; the pointer resets to L so North wins the first round
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      for (int o = 0; o < NPORT; o++) begin
        lock_q[o]   <= IDLE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= ROUTE_W'(NPORT - 1);
      end
      dest_err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        lock_q[o]   <= lock_d[o];
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
      end
      dest_err_q <= dest_err_d;
    end
  end

  assign address_route_n_o = route_sel[0];
  assign address_route_s_o = route_sel[1];
  assign address_route_e_o = route_sel[2];
  assign address_route_w_o = route_sel[3];
  assign address_route_l_o = route_sel[4];
  assign dest_err_o        = dest_err_q;

endmodule

// File: tb/tb_xbar_sw_alloc.sv
// Self-checking bench for xbar_sw_alloc: directed vector tables, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_xbar_sw_alloc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req_valid;
  logic [14:0] req_dest;
  logic [4:0]  req_tail;
  logic [4:0]  out_ready;
  logic [2:0]  rn, rs, re, rw, rl;
  logic [4:0]  ov, gr;
  logic        err;
  logic [14:0] routes;

  int n_checks = 0;
  int n_fail   = 0;

  xbar_sw_alloc dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid),
    .req_dest_i        (req_dest),
    .req_tail_i        (req_tail),
    .out_ready_i       (out_ready),
    .address_route_n_o (rn),
    .address_route_s_o (rs),
    .address_route_e_o (re),
    .address_route_w_o (rw),
    .address_route_l_o (rl),
    .out_valid_o       (ov),
    .grant_o           (gr),
    .dest_err_o        (err)
  );

  assign routes = {rl, rw, re, rs, rn};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner [5];   // -1 when the output is free, else owning input
  int m_last  [5];   // input that most recently won the output
  bit m_err;

  function automatic bit vbit(input logic [4:0] v, input int i);
    return ((v >> i) & 5'd1) != 5'd0;
  endfunction

  function automatic int dest_of(input int k);
    logic [14:0] d;
    d = req_dest >> (3 * k);
    return int'(d[2:0]);
  endfunction

  function automatic void model_reset();
    for (int o = 0; o < 5; o++) begin
      m_owner[o] = -1;
      m_last[o]  = 4;
    end
    m_err = 1'b0;
  endfunction

  function automatic void model_outputs(output logic [14:0] er, output logic [4:0] ev,
                                        output logic [4:0] eg);
    er = '1;
    ev = '0;
    eg = '0;
    for (int o = 0; o < 5; o++) begin
      if (m_owner[o] >= 0) begin
        int w;
        w  = m_owner[o];
        er = (er & ~(15'h7 << (3 * o))) | (15'(w) << (3 * o));
        if (vbit(req_valid, w) && dest_of(w) == o && vbit(out_ready, o)) begin
          ev = ev | (5'd1 << o);
          eg = eg | (5'd1 << w);
        end
      end
    end
  endfunction

  // Free outputs go to the requester closest after the last winner (the last
  // winner itself is farthest); owned outputs free up after a tail transfer.
  function automatic void model_update();
    for (int o = 0; o < 5; o++) begin
      if (m_owner[o] < 0) begin
        int best;
        int bestd;
        best  = -1;
        bestd = 6;
        for (int k = 0; k < 5; k++) begin
          if (vbit(req_valid, k) && dest_of(k) == o) begin
            int d;
            d = (k - m_last[o] + 5) % 5;
            if (d == 0) d = 5;
            if (d < bestd) begin
              bestd = d;
              best  = k;
            end
          end
        end
        if (best >= 0) begin
          m_owner[o] = best;
          m_last[o]  = best;
        end
      end else begin
        int w;
        w = m_owner[o];
        if (vbit(req_valid, w) && dest_of(w) == o && vbit(out_ready, o) && vbit(req_tail, w))
          m_owner[o] = -1;
      end
    end
    for (int k = 0; k < 5; k++)
      if (vbit(req_valid, k) && dest_of(k) > 4) m_err = 1'b1;
  endfunction

  // Called at posedge+1 with inputs already driven; compares against the
  // model mid-cycle, then advances one clock.
  task automatic step(input string tag, output logic [4:0] eg_o);
    logic [14:0] er;
    logic [4:0]  ev, eg;
    #3;
    model_outputs(er, ev, eg);
    check({tag, " route"},    32'(routes), 32'(er));
    check({tag, " out_valid"}, 32'(ov),    32'(ev));
    check({tag, " grant"},    32'(gr),     32'(eg));
    check({tag, " dest_err"}, 32'(err),    32'(m_err));
    eg_o = eg;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_dest  = '0;
    req_tail  = '0;
    out_ready = '1;
    #1;
    check("reset route",     32'(routes), 32'h7fff);
    check("reset out_valid", 32'(ov),     32'h0);
    check("reset grant",     32'(gr),     32'h0);
    check("reset dest_err",  32'(err),    32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rst_first;
    logic [4:0]  valid;
    logic [14:0] dest;
    logic [4:0]  tail;
    logic [4:0]  ready;
    logic [14:0] exp_route;
    logic [4:0]  exp_ov;
    logic [4:0]  exp_gr;
  } vec_t;

  vec_t vecs[$];
  int   rem [5];

  initial begin
    logic [4:0] g;
    rst_n     = 1'b1;
    req_valid = '0;
    req_dest  = '0;
    req_tail  = '0;
    out_ready = '1;
    model_reset();
    #1;

    // W -> E, three flits: one arbitration cycle, three transfers, one idle
    vecs.push_back('{1'b1, 5'b01000, 15'b000_010_000_000_000, 5'b00000, 5'b11111,
                     15'b111_111_111_111_111, 5'b00000, 5'b00000});
    vecs.push_back('{1'b0, 5'b01000, 15'b000_010_000_000_000, 5'b00000, 5'b11111,
                     15'b111_111_011_111_111, 5'b00100, 5'b01000});
    vecs.push_back('{1'b0, 5'b01000, 15'b000_010_000_000_000, 5'b00000, 5'b11111,
                     15'b111_111_011_111_111, 5'b00100, 5'b01000});
    vecs.push_back('{1'b0, 5'b01000, 15'b000_010_000_000_000, 5'b01000, 5'b11111,
                     15'b111_111_011_111_111, 5'b00100, 5'b01000});
    vecs.push_back('{1'b0, 5'b00000, 15'b000_010_000_000_000, 5'b00000, 5'b11111,
                     15'b111_111_111_111_111, 5'b00000, 5'b00000});
    // N, S, L single flits all to L: N, S, L, N with a bubble between each
    vecs.push_back('{1'b1, 5'b10011, 15'b100_000_000_100_100, 5'b10011, 5'b11111,
                     15'b111_111_111_111_111, 5'b00000, 5'b00000});
    vecs.push_back('{1'b0, 5'b10011, 15'b100_000_000_100_100, 5'b10011, 5'b11111,
                     15'b000_111_111_111_111, 5'b10000, 5'b00001});
    vecs.push_back('{1'b0, 5'b10011, 15'b100_000_000_100_100, 5'b10011, 5'b11111,
                     15'b111_111_111_111_111, 5'b00000, 5'b00000});
    vecs.push_back('{1'b0, 5'b10011, 15'b100_000_000_100_100, 5'b10011, 5'b11111,
                     15'b001_111_111_111_111, 5'b10000, 5'b00010});
    vecs.push_back('{1'b0, 5'b10011, 15'b100_000_000_100_100, 5'b10011, 5'b11111,
                     15'b111_111_111_111_111, 5'b00000, 5'b00000});
    vecs.push_back('{1'b0, 5'b10011, 15'b100_000_000_100_100, 5'b10011, 5'b11111,
                     15'b100_111_111_111_111, 5'b10000, 5'b10000});
    vecs.push_back('{1'b0, 5'b10011, 15'b100_000_000_100_100, 5'b10011, 5'b11111,
                     15'b111_111_111_111_111, 5'b00000, 5'b00000});
    vecs.push_back('{1'b0, 5'b10011, 15'b100_000_000_100_100, 5'b10011, 5'b11111,
                     15'b000_111_111_111_111, 5'b10000, 5'b00001});

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      req_valid = vecs[i].valid;
      req_dest  = vecs[i].dest;
      req_tail  = vecs[i].tail;
      out_ready = vecs[i].ready;
      #2;
      check($sformatf("vec%0d route", i),     32'(routes), 32'(vecs[i].exp_route));
      check($sformatf("vec%0d out_valid", i), 32'(ov),     32'(vecs[i].exp_ov));
      check($sformatf("vec%0d grant", i),     32'(gr),     32'(vecs[i].exp_gr));
      step("vec", g);
    end

    // Backpressure: W->E stalls 4 cycles, a competing N->E waits for the tail
    do_reset();
    req_valid = 5'b01000;
    req_dest  = 15'b000_010_000_000_010;
    req_tail  = 5'b00001;
    step("bp arb", g);
    step("bp flit1", g);
    req_valid = 5'b01001;
    out_ready = 5'b11011;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("bp stall route_e", 32'(re), 32'h3);
      check("bp stall grant",   32'(gr), 32'h0);
      check("bp stall ov",      32'(ov), 32'h0);
      step("bp stall", g);
    end
    out_ready = '1;
    #2;
    check("bp flit2 grant", 32'(gr), 32'h08);
    step("bp flit2", g);
    req_tail = 5'b01001;
    #2;
    check("bp tail grant", 32'(gr), 32'h08);
    check("bp tail route_e", 32'(re), 32'h3);
    step("bp tail", g);
    req_valid = 5'b00001;
    #2;
    check("bp bubble route_e", 32'(re), 32'h7);
    step("bp bubble", g);
    #2;
    check("bp N route_e", 32'(re), 32'h0);
    check("bp N grant",   32'(gr), 32'h01);
    step("bp N", g);
    req_valid = '0;
    step("bp drain", g);

    // Parallel: N->S and E->W lock and transfer in the same cycles
    do_reset();
    req_valid = 5'b00101;
    req_dest  = 15'b000_000_011_000_001;
    req_tail  = '0;
    step("par arb", g);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) req_tail = 5'b00101;
      #2;
      check("par route_s", 32'(rs), 32'h0);
      check("par route_w", 32'(rw), 32'h2);
      check("par grant",   32'(gr), 32'h05);
      check("par ov",      32'(ov), 32'h0a);
      step("par xfer", g);
    end
    req_valid = '0;
    step("par idle", g);

    // Bad dest on L, sticky error, then reset mid-packet on W->E
    do_reset();
    req_valid = 5'b11000;
    req_dest  = 15'b110_010_000_000_000;
    req_tail  = '0;
    #2;
    check("bad err before", 32'(err), 32'h0);
    step("bad arb", g);
    #2;
    check("bad err set",  32'(err), 32'h1);
    check("bad grant",    32'(gr),  32'h08);
    step("bad xfer", g);
    req_valid = 5'b01000;
    #2;
    check("bad err sticky", 32'(err), 32'h1);
    step("bad sticky", g);
    do_reset();
    req_valid = 5'b01000;
    req_dest  = 15'b000_010_000_000_000;
    #2;
    check("post reset route_e", 32'(re), 32'h7);
    step("post reset", g);
    req_valid = '0;
    step("post reset drain", g);

    // Randomized traffic: per-input packets with held destinations
    do_reset();
    for (int k = 0; k < 5; k++) rem[k] = 0;
    for (int c = 0; c < 600; c++) begin
      logic [4:0] v, t, r;
      v = '0;
      t = '0;
      r = '0;
      for (int k = 0; k < 5; k++) begin
        if (rem[k] == 0) begin
          rem[k]   = int'($urandom_range(1, 4));
          req_dest = (req_dest & ~(15'h7 << (3 * k))) |
                     (15'($urandom_range(0, 4)) << (3 * k));
        end
        if ($urandom_range(0, 3) != 0) v = v | (5'd1 << k);
        if (rem[k] == 1)               t = t | (5'd1 << k);
        if ($urandom_range(0, 3) != 0) r = r | (5'd1 << k);
      end
      req_valid = v;
      req_tail  = t;
      out_ready = r;
      step("rand", g);
      for (int k = 0; k < 5; k++)
        if (vbit(g, k)) rem[k] = rem[k] - 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
